// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares RAM port A between the CPU (fixed priority) and a secondary
// word-wide requester. A starvation counter forces a one-cycle CPU stall
// (FORCE state) so the secondary requester always makes progress. CPU load
// data returned during a forced stall is held for the cycle after it.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_ready,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  // Counter value at which the current refusal is the last one tolerated.
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;
  logic        w_cpu_active;
  logic        w_ext_ready;
  logic        r_ext_rvalid;
  logic        r_cpu_rd_prev;
  logic        r_hold_vld;
  logic [31:0] r_hold_data;

  assign w_cpu_active = cpu_re | (|cpu_we);

  // Port mux: FORCE hands the port to ext, otherwise CPU first, then ext.
  always_comb begin
    w_ext_ready = 1'b0;
    ram_we      = 4'b0000;
    ram_addr    = cpu_addr;
    ram_din     = cpu_wdata;
    if (rst) begin
      w_ext_ready = 1'b0;
      ram_we      = 4'b0000;
    end else if (r_state == ST_FORCE) begin
      ram_addr    = ext_addr;
      ram_din     = ext_wdata;
      w_ext_ready = ext_req;
      ram_we      = (ext_req && ext_we) ? 4'b1111 : 4'b0000;
    end else if (w_cpu_active) begin
      ram_we      = cpu_we;
    end else if (ext_req) begin
      ram_addr    = ext_addr;
      ram_din     = ext_wdata;
      w_ext_ready = 1'b1;
      ram_we      = {4{ext_we}};
    end else begin
      ram_we      = 4'b0000;
    end
  end

  // Next state and starvation count; FORCE always lasts exactly one cycle.
  always_comb begin
    w_state_nxt  = ST_NORMAL;
    w_starve_nxt = 4'd0;
    case (r_state)
      ST_NORMAL: begin
        if (ext_req && !w_ext_ready) begin
          if (r_starve_cnt == STARVE_LAST) begin
            w_state_nxt  = ST_FORCE;
            w_starve_nxt = 4'd0;
          end else begin
            w_state_nxt  = ST_NORMAL;
            w_starve_nxt = r_starve_cnt + 4'd1;
          end
        end else begin
          w_state_nxt  = ST_NORMAL;
          w_starve_nxt = 4'd0;
        end
      end
      ST_FORCE: begin
        w_state_nxt  = ST_NORMAL;
        w_starve_nxt = 4'd0;
      end
      default: begin
        w_state_nxt  = ST_NORMAL;
        w_starve_nxt = 4'd0;
      end
    endcase
  end

  // State register, starvation counter and ext read-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_NORMAL;
      r_starve_cnt <= 4'd0;
      r_ext_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_ext_rvalid <= w_ext_ready && !ext_we;
    end
  end

  // Capture CPU load data that returns while the pipeline is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rd_prev <= 1'b0;
      r_hold_vld    <= 1'b0;
      r_hold_data   <= 32'h0000_0000;
    end else begin
      r_cpu_rd_prev <= (r_state == ST_NORMAL) && cpu_re;
      r_hold_vld    <= (r_state == ST_FORCE) && r_cpu_rd_prev;
      if ((r_state == ST_FORCE) && r_cpu_rd_prev) begin
        r_hold_data <= ram_dout;
      end else begin
        r_hold_data <= r_hold_data;
      end
    end
  end

  assign cpu_stall  = (r_state == ST_FORCE);
  assign cpu_rdata  = r_hold_vld ? r_hold_data : ram_dout;
  assign ext_ready  = w_ext_ready;
  assign ext_rvalid = r_ext_rvalid;
  assign ext_rdata  = ram_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural model that tracks
// refusal runs, expected port ownership and a shadow copy of memory.
module tb_dmem_port_arbiter;
  localparam int AW = 12;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_re;
  logic [3:0]    cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [31:0]   ext_wdata;
  logic          ext_ready;
  logic          ext_rvalid;
  logic [31:0]   ext_rdata;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  int n_total = 0;
  int n_bad   = 0;

  // RAM contents driven by the DUT, and the model's own shadow copy.
  logic [31:0] ram     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  // Model state.
  bit          m_force;
  int          m_run;
  bit          m_rv;
  logic [31:0] m_rv_data;
  bit          m_due;
  logic [31:0] m_cpu_data;
  bit          obs_ready;
  bit          obs_stall;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Block RAM model: read-first, byte enables big-endian (bit3 = [31:24]).
  always @(posedge clk) begin
    if (ram_we[3]) ram[ram_addr][31:24] <= ram_din[31:24];
    if (ram_we[2]) ram[ram_addr][23:16] <= ram_din[23:16];
    if (ram_we[1]) ram[ram_addr][15:8]  <= ram_din[15:8];
    if (ram_we[0]) ram[ram_addr][7:0]   <= ram_din[7:0];
    ram_dout <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    if (be[3]) r[31:24] = din[31:24];
    if (be[2]) r[23:16] = din[23:16];
    if (be[1]) r[15:8]  = din[15:8];
    if (be[0]) r[7:0]   = din[7:0];
    return r;
  endfunction

  // One clock cycle: inputs are already set; check outputs, advance model.
  task automatic step();
    bit          cpu_act;
    bit          e_ready;
    bit          f_next;
    logic [3:0]  e_we;
    logic [AW-1:0] e_addr;
    logic [31:0] e_din;
    logic [31:0] rd_ext;
    logic [31:0] rd_cpu;
    #2;
    cpu_act   = cpu_re || (cpu_we != 4'd0);
    obs_ready = ext_ready;
    obs_stall = cpu_stall;
    check("cpu_stall", 32'(cpu_stall), 32'(m_force));
    check("ext_rvalid", 32'(ext_rvalid), 32'(m_rv));
    if (m_rv) check("ext_rdata", ext_rdata, m_rv_data);
    if (m_due) check("cpu_rdata", cpu_rdata, m_cpu_data);

    // Who owns the port this cycle.
    if (rst) begin
      e_ready = 1'b0; e_we = 4'd0; e_addr = cpu_addr; e_din = cpu_wdata;
    end else if (m_force) begin
      e_ready = ext_req; e_we = (ext_req && ext_we) ? 4'hF : 4'h0;
      e_addr = ext_addr; e_din = ext_wdata;
    end else if (cpu_act) begin
      e_ready = 1'b0; e_we = cpu_we; e_addr = cpu_addr; e_din = cpu_wdata;
    end else if (ext_req) begin
      e_ready = 1'b1; e_we = ext_we ? 4'hF : 4'h0; e_addr = ext_addr; e_din = ext_wdata;
    end else begin
      e_ready = 1'b0; e_we = 4'd0; e_addr = cpu_addr; e_din = cpu_wdata;
    end
    check("ext_ready", 32'(ext_ready), 32'(e_ready));
    check("ram_we", 32'(ram_we), 32'(e_we));
    if (!rst) check("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (e_we != 4'd0) check("ram_din", ram_din, e_din);

    // Advance the model.
    rd_ext = ref_mem[ext_addr];
    rd_cpu = ref_mem[cpu_addr];
    f_next = !rst && !m_force && ext_req && !e_ready && (m_run + 1 >= SM);
    if (!rst && !m_force && cpu_re) m_cpu_data = rd_cpu;
    m_due     = !rst && ((!m_force && cpu_re) || (m_force && m_due));
    m_rv      = !rst && e_ready && !ext_we;
    m_rv_data = rd_ext;
    if (!rst && e_we != 4'd0) ref_mem[e_addr] = merge(ref_mem[e_addr], e_din, e_we);
    if (rst || e_ready || !ext_req || m_force || f_next) m_run = 0;
    else m_run = m_run + 1;
    m_force = f_next;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; cpu_re = 1'b0; cpu_we = 4'd0; cpu_addr = '0; cpu_wdata = 32'd0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = 32'd0;
  endtask

  task automatic ext_write(input logic [AW-1:0] a, input logic [31:0] d);
    idle(); ext_req = 1'b1; ext_we = 1'b1; ext_addr = a; ext_wdata = d;
    step();
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      ram[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    m_force = 0; m_run = 0; m_rv = 0; m_due = 0;
    m_rv_data = 32'd0; m_cpu_data = 32'd0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;
    // Reset state visible after reset.
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_rvalid", 32'(ext_rvalid), 32'd0);

    // Ext write then read with an idle CPU.
    ext_write(12'd5, 32'hDEADBEEF);
    check("tp1_wr_ready", 32'(obs_ready), 32'd1);
    idle(); ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'd5;
    step();
    check("tp1_rd_ready", 32'(obs_ready), 32'd1);
    check("tp1_rvalid", 32'(ext_rvalid), 32'd1);
    check("tp1_rdata", ext_rdata, 32'hDEADBEEF);
    idle(); step();

    // CPU loads every cycle, ext held: four refusals then a forced cycle.
    idle(); cpu_re = 1'b1; cpu_addr = 12'd1; ext_req = 1'b1; ext_addr = 12'd5;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("tp2_ready%0d", i), 32'(obs_ready), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("tp2_stall%0d", i), 32'(obs_stall), (i == 4) ? 32'd1 : 32'd0);
    end
    idle(); step();

    // CPU load data held across a forced stall.
    ext_write(12'd3, 32'h11223344);
    ext_write(12'd7, 32'hA5A50007);
    idle(); step();
    idle(); cpu_re = 1'b1; cpu_addr = 12'd3; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'd7;
    for (int i = 0; i < 5; i++) step();
    check("tp3_stall_seen", 32'(obs_stall), 32'd1);
    check("tp3_cpu_rdata", cpu_rdata, 32'h11223344);
    check("tp3_ext_rdata", ext_rdata, 32'hA5A50007);
    idle(); step();

    // CPU byte store into addr 2 while ext is refused.
    ext_write(12'd2, 32'hAABBCCDD);
    idle(); cpu_we = 4'b0100; cpu_addr = 12'd2; cpu_wdata = 32'h11111111;
    ext_req = 1'b1; ext_addr = 12'd9;
    step();
    check("tp4_refused", 32'(obs_ready), 32'd0);
    idle(); ext_req = 1'b1; ext_addr = 12'd2;
    step();
    check("tp4_byte1", ext_rdata, 32'hAA11CCDD);
    idle(); step();

    // Ext request dropped during the forced cycle.
    idle(); cpu_re = 1'b1; ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'd20;
    for (int i = 0; i < SM; i++) step();
    ext_req = 1'b0;
    step();
    check("tp5_stall", 32'(obs_stall), 32'd1);
    check("tp5_ready", 32'(obs_ready), 32'd0);
    ext_req = 1'b1;
    for (int i = 0; i < SM + 2; i++) step();
    idle(); step();

    // Reset asserted in the forced cycle.
    idle(); cpu_re = 1'b1; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'd7;
    for (int i = 0; i < SM; i++) step();
    rst = 1'b1;
    step();
    check("tp6_in_force", 32'(obs_stall), 32'd1);
    rst = 1'b0;
    step();
    check("tp6_no_stall", 32'(obs_stall), 32'd0);
    check("tp6_rvalid", 32'(ext_rvalid), 32'd0);
    idle(); step();

    // Randomized traffic in phases of varying CPU pressure.
    for (int ph = 0; ph < 8; ph++) begin
      int cpu_pct;
      int ext_pct;
      cpu_pct = 20 + ph * 10;
      ext_pct = 30 + (ph % 3) * 30;
      for (int c = 0; c < 300; c++) begin
        idle();
        rst = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 99) < cpu_pct) begin
          if ($urandom_range(0, 3) == 0) cpu_we = 4'($urandom_range(1, 15));
          else cpu_re = 1'b1;
        end
        cpu_addr  = 12'($urandom_range(0, 15));
        cpu_wdata = $urandom;
        ext_req   = ($urandom_range(0, 99) < ext_pct);
        ext_we    = ($urandom_range(0, 2) == 0);
        ext_addr  = 12'($urandom_range(0, 15));
        ext_wdata = $urandom;
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single read/write port A of the data memory block RAM between the CPU (store/load address from the X stage) and a secondary word-wide requester (boot loader / debug DMA). The CPU has fixed priority. A starvation counter forces a one-cycle CPU pipeline stall so the secondary requester is guaranteed forward progress. The block sits between the datapath's DMEM connections and the RAM primitive, and also owns CPU load-data holding across a forced stall.

## Interface

Parameters:
- ADDR_W, 12, word address width of the RAM (bytes addressed as word address, 4-bit byte enables)
- STARVE_MAX, 4, consecutive refused ext cycles before a forced grant (legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cpu_re  in  1  CPU load access this cycle
- cpu_we  in  4  CPU byte write enables (bit3 = byte0 = [31:24], big-endian)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  CPU load data, valid the cycle after the access
- cpu_stall  out  1  freeze whole CPU pipeline this cycle
- ext_req  in  1  secondary requester has a pending access
- ext_we  in  1  1 = write full word, 0 = read
- ext_addr  in  ADDR_W  ext word address
- ext_wdata  in  32  ext write data
- ext_ready  out  1  ext access performed this cycle (req && ready = handshake)
- ext_rvalid  out  1  ext read data valid
- ext_rdata  out  32  ext read data
- ram_we  out  4  to RAM wea
- ram_addr  out  ADDR_W  to RAM addra
- ram_din  out  32  to RAM dina
- ram_dout  in  32  from RAM douta (1-cycle read latency)

## Operation

- cpu_active = cpu_re | (|cpu_we).
- States: NORMAL, FORCE. Reset -> NORMAL.
- NORMAL: if cpu_active, RAM port driven from cpu_* and ext_ready=0; else if ext_req, port driven from ext_* (ram_we = {4{ext_we}}) and ext_ready=1; else ram_we=0, ram_addr=cpu_addr.
- FORCE: cpu_stall=1; port driven from ext_* regardless of cpu inputs; ext_ready=ext_req. If ext_req is low in FORCE, ram_we=0 and the cycle is wasted (still a stall).
- starve_cnt (4 bits): cleared on reset, on any ext_ready=1, or when ext_req=0; incremented when ext_req && !ext_ready in NORMAL.
- NORMAL -> FORCE when ext_req && !ext_ready && starve_cnt == STARVE_MAX-1. FORCE -> NORMAL always after one cycle; starve_cnt=0 on exit, so FORCE is never back-to-back.
- CPU access presented during FORCE is ignored; the frozen CPU re-presents it next cycle.
- Load-data hold: if FORCE follows a CPU read cycle, ram_dout during FORCE is captured into hold_reg; in the first cycle after FORCE, cpu_rdata = hold_reg; otherwise cpu_rdata = ram_dout.
- ext_rvalid: registered, set the cycle after an ext read handshake (ext_ready && !ext_we); ext_rdata = ram_dout.

## Timing

- Reset values: state NORMAL, starve_cnt 0, cpu_stall 0, ext_rvalid 0, hold flag 0; ext_ready 0 while rst is high; ram_we 0 while rst is high.
- cpu_stall is a registered state decode: asserted exactly one cycle, STARVE_MAX cycles after an ext request starts being refused.
- ext_ready, ram_* are combinational from state and inputs; no combinational path from ram_dout to ram_*.
- Ext read latency 1 cycle; CPU load latency 1 cycle (2 only in the hold case, seen as same-cycle by a frozen CPU).
- Worst-case ext wait: STARVE_MAX cycles from first refusal to handshake.
- Reset mid-FORCE: next cycle NORMAL, no stall, pending rvalid dropped.

## Test plan

- Idle CPU, ext write addr 5 data 32'hDEADBEEF then read addr 5 -> ext_ready high both cycles, ext_rvalid one cycle later with ext_rdata 32'hDEADBEEF.
- CPU load every cycle, ext_req held, STARVE_MAX=4 -> ext_ready 0 for 4 cycles, cpu_stall=1 and ext_ready=1 in 5th cycle, no stall in 6th.
- CPU load addr 3 (32'h11223344) in cycle N, FORCE in N+1 with ext read addr 7 -> cpu_rdata=32'h11223344 in N+2, ext_rdata=addr 7 contents in N+2.
- CPU SB cpu_we=4'b0100 addr 2 while ext_req -> only byte1 written, ext refused, starve_cnt increments.
- ext_req dropped during FORCE -> ram_we=0, stall still 1 cycle, starve_cnt 0 afterward.
- rst asserted in FORCE -> next cycle cpu_stall=0, ext_rvalid=0, state NORMAL.
